// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared encodings for the UART command parser
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CH    = 3'd1,
        ST_WAVE  = 3'd2,
        ST_ADDER = 3'd3,
        ST_AMPL  = 3'd4,
        ST_CHK   = 3'd5,
        ST_EOM   = 3'd6
    } state_t;

    localparam logic [7:0] SOM_BYTE = 8'h73;
    localparam logic [7:0] EOM_BYTE = 8'h65;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_UART     = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd2;
    localparam logic [2:0] ERR_CHECKSUM = 3'd3;
    localparam logic [2:0] ERR_EOM      = 3'd4;
    localparam logic [2:0] ERR_CHANNEL  = 3'd5;

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap timer, expires after TIMEOUT_CYC idle cycles
module uart_gap_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count_q;

    // count_q holds the number of idle cycles already elapsed, so expiry is flagged on the last one
    assign expired = enable && (count_q >= CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            count_q <= '0;
        end else if (!expired) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed UART command parser committing per-channel waveform settings
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDER_W     = 32,
    parameter int AMPL_W      = 32,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int ADDER_RST   = 214748,
    parameter int AMPL_RST    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  from_uart_ready,
    input  logic [7:0]            from_uart_data,
    input  logic                  from_uart_error,
    input  logic                  from_uart_valid,
    output logic [NUM_CH*8-1:0]   wave_sel,
    output logic [NUM_CH*ADDER_W-1:0] adder,
    output logic [NUM_CH*AMPL_W-1:0]  amplitude,
    output logic                  update_valid,
    output logic [7:0]            update_ch,
    output logic                  err_valid,
    output logic [2:0]            err_code,
    output logic [15:0]           err_count
);

    localparam int ADB = ADDER_W / 8;
    localparam int AMB = AMPL_W / 8;

    state_t               state_q;
    logic                 ready_q;
    logic [1:0]           cnt_q;
    logic [7:0]           ch_q;
    logic [7:0]           wave_sh_q;
    logic [ADDER_W-1:0]   adder_sh_q;
    logic [AMPL_W-1:0]    ampl_sh_q;
    logic [7:0]           xor_q;
    logic                 chk_ok_q;
    logic                 update_valid_q;
    logic [7:0]           update_ch_q;
    logic                 err_valid_q;
    logic [2:0]           err_code_q;
    logic [15:0]          err_count_q;

    logic                 byte_acc;
    logic                 tmo_expired;
    logic                 ch_ok;
    logic                 commit;
    logic                 err_fire;
    logic [2:0]           err_code_d;

    assign byte_acc = from_uart_valid && ready_q;
    assign ch_ok    = ({1'b0, ch_q} < 9'(NUM_CH));

    uart_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (byte_acc),
        .enable  (state_q != ST_IDLE),
        .expired (tmo_expired)
    );

    // Frame verdict at the EOM byte; an arriving byte always wins over a coincident timeout
    always_comb begin
        err_fire   = 1'b0;
        err_code_d = ERR_NONE;
        commit     = 1'b0;
        if (byte_acc && from_uart_error) begin
            err_fire   = 1'b1;
            err_code_d = ERR_UART;
        end else if (byte_acc && state_q == ST_EOM) begin
            if (from_uart_data != EOM_BYTE) begin
                err_fire   = 1'b1;
                err_code_d = ERR_EOM;
            end else if (!chk_ok_q) begin
                err_fire   = 1'b1;
                err_code_d = ERR_CHECKSUM;
            end else if (!ch_ok) begin
                err_fire   = 1'b1;
                err_code_d = ERR_CHANNEL;
            end else begin
                commit = 1'b1;
            end
        end else if (!byte_acc && tmo_expired) begin
            err_fire   = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ready_q        <= 1'b0;
            cnt_q          <= '0;
            ch_q           <= '0;
            wave_sh_q      <= '0;
            adder_sh_q     <= '0;
            ampl_sh_q      <= '0;
            xor_q          <= '0;
            chk_ok_q       <= 1'b0;
            update_valid_q <= 1'b0;
            update_ch_q    <= '0;
            err_valid_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
            err_count_q    <= '0;
        end else begin
            ready_q        <= 1'b1;
            update_valid_q <= commit;
            err_valid_q    <= err_fire;
            if (commit) begin
                update_ch_q <= ch_q;
            end
            if (err_fire) begin
                err_code_q <= err_code_d;
                if (err_count_q != 16'hFFFF) begin
                    err_count_q <= err_count_q + 16'd1;
                end
            end
            if (err_fire) begin
                state_q <= ST_IDLE;
            end else if (byte_acc) begin
                case (state_q)
                    ST_IDLE: begin
                        if (from_uart_data == SOM_BYTE) begin
                            state_q <= ST_CH;
                            xor_q   <= '0;
                            cnt_q   <= '0;
                        end
                    end
                    ST_CH: begin
                        ch_q    <= from_uart_data;
                        xor_q   <= xor_q ^ from_uart_data;
                        state_q <= ST_WAVE;
                    end
                    ST_WAVE: begin
                        wave_sh_q <= from_uart_data;
                        xor_q     <= xor_q ^ from_uart_data;
                        cnt_q     <= '0;
                        state_q   <= ST_ADDER;
                    end
                    ST_ADDER: begin
                        adder_sh_q <= (adder_sh_q << 8) | ADDER_W'(from_uart_data);
                        xor_q      <= xor_q ^ from_uart_data;
                        if (cnt_q == 2'(ADB - 1)) begin
                            cnt_q   <= '0;
                            state_q <= ST_AMPL;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                    ST_AMPL: begin
                        ampl_sh_q <= (ampl_sh_q << 8) | AMPL_W'(from_uart_data);
                        xor_q     <= xor_q ^ from_uart_data;
                        if (cnt_q == 2'(AMB - 1)) begin
                            cnt_q   <= '0;
                            state_q <= ST_CHK;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                    ST_CHK: begin
                        chk_ok_q <= (from_uart_data == xor_q);
                        state_q  <= ST_EOM;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [7:0]         wave_q;
        logic [ADDER_W-1:0] adder_q;
        logic [AMPL_W-1:0]  ampl_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                wave_q  <= '0;
                adder_q <= ADDER_W'(ADDER_RST);
                ampl_q  <= AMPL_W'(AMPL_RST);
            end else if (commit && ch_q == 8'(g)) begin
                wave_q  <= wave_sh_q;
                adder_q <= adder_sh_q;
                ampl_q  <= ampl_sh_q;
            end
        end

        assign wave_sel[g*8 +: 8]             = wave_q;
        assign adder[g*ADDER_W +: ADDER_W]    = adder_q;
        assign amplitude[g*AMPL_W +: AMPL_W]  = ampl_q;
    end

    assign from_uart_ready = ready_q;
    assign update_valid    = update_valid_q;
    assign update_ch       = update_ch_q;
    assign err_valid       = err_valid_q;
    assign err_code        = err_code_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - randomized self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam int NCH = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                from_uart_ready;
    logic [7:0]          from_uart_data = 8'h00;
    logic                from_uart_error = 1'b0;
    logic                from_uart_valid = 1'b0;
    logic [NCH*8-1:0]    wave_sel;
    logic [NCH*32-1:0]   adder;
    logic [NCH*32-1:0]   amplitude;
    logic                update_valid;
    logic [7:0]          update_ch;
    logic                err_valid;
    logic [2:0]          err_code;
    logic [15:0]         err_count;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .NUM_CH(NCH), .ADDER_W(32), .AMPL_W(32), .TIMEOUT_CYC(100),
        .ADDER_RST(214748), .AMPL_RST(255)
    ) dut (
        .clk(clk), .reset(reset),
        .from_uart_ready(from_uart_ready), .from_uart_data(from_uart_data),
        .from_uart_error(from_uart_error), .from_uart_valid(from_uart_valid),
        .wave_sel(wave_sel), .adder(adder), .amplitude(amplitude),
        .update_valid(update_valid), .update_ch(update_ch),
        .err_valid(err_valid), .err_code(err_code), .err_count(err_count)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          upd_seen = 0;
    int          err_seen = 0;

    logic [7:0]  exp_wave[NCH];
    logic [31:0] exp_adder[NCH];
    logic [31:0] exp_ampl[NCH];
    logic [2:0]  exp_code;
    logic [15:0] exp_count;
    logic [7:0]  exp_upd_ch;
    int          exp_upd = 0;
    int          exp_errp = 0;
    logic [7:0]  frm[13];

    // Pulse counting, plus the rule that commit and error pulses are exclusive
    always @(negedge clk) begin
        if (!reset) begin
            if (update_valid || err_valid) begin
                n_checks++;
                if (update_valid && err_valid) begin
                    n_fail++;
                    $display("FAIL pulse_overlap: update_valid=%b err_valid=%b required not both", update_valid, err_valid);
                end
            end
            if (update_valid) upd_seen++;
            if (err_valid) err_seen++;
        end
    end

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            exp_wave[c]  = 8'h00;
            exp_adder[c] = 32'd214748;
            exp_ampl[c]  = 32'd255;
        end
        exp_code   = 3'd0;
        exp_count  = 16'd0;
        exp_upd_ch = 8'd0;
    endtask

    task automatic model_err(input logic [2:0] code);
        exp_code = code;
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        exp_errp++;
    endtask

    task automatic model_frame(input int err_at);
        logic [7:0] x;
        int c;
        x = 8'h00;
        for (int i = 1; i <= 10; i++) x = x ^ frm[i];
        if (err_at >= 0) model_err(3'd1);
        else if (frm[12] != 8'h65) model_err(3'd4);
        else if (frm[11] != x) model_err(3'd3);
        else if (frm[1] >= NCH) model_err(3'd5);
        else begin
            c = int'(frm[1]);
            exp_wave[c]  = frm[2];
            exp_adder[c] = {frm[3], frm[4], frm[5], frm[6]};
            exp_ampl[c]  = {frm[7], frm[8], frm[9], frm[10]};
            exp_upd_ch   = frm[1];
            exp_upd++;
        end
    endtask

    task automatic build_frame(input logic [7:0] ch, input logic [7:0] wave,
                               input logic [31:0] add, input logic [31:0] amp);
        frm[0] = 8'h73; frm[1] = ch; frm[2] = wave;
        for (int i = 0; i < 4; i++) begin
            frm[3+i] = add[31-8*i -: 8];
            frm[7+i] = amp[31-8*i -: 8];
        end
        frm[11] = 8'h00;
        for (int i = 1; i <= 10; i++) frm[11] = frm[11] ^ frm[i];
        frm[12] = 8'h65;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e, input int gap);
        int w;
        w = 0;
        while (!from_uart_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (!from_uart_ready) begin
            n_fail++;
            $display("FAIL ready_wait: ready=%b required 1", from_uart_ready);
        end
        from_uart_data = d; from_uart_error = e; from_uart_valid = 1'b1;
        @(posedge clk); #1;
        from_uart_error = 1'b0;
        if (gap > 0) begin
            from_uart_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        from_uart_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int err_at, input int n_bytes, input int maxgap);
        for (int i = 0; i < n_bytes; i++) begin
            send_byte(frm[i], i == err_at, $urandom_range(maxgap, 0));
            if (i == err_at) break;
        end
        from_uart_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (from_uart_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b required 0", from_uart_ready);
        end
        for (int c = 0; c < NCH; c++) begin
            n_checks++;
            if ({wave_sel[c*8 +: 8], adder[c*32 +: 32], amplitude[c*32 +: 32]} !== {exp_wave[c], exp_adder[c], exp_ampl[c]}) begin
                n_fail++; $display("FAIL reset_ch%0d: got %h required %h", c, {wave_sel[c*8 +: 8], adder[c*32 +: 32], amplitude[c*32 +: 32]}, {exp_wave[c], exp_adder[c], exp_ampl[c]});
            end
        end
        n_checks++;
        if ({update_valid, update_ch, err_valid, err_code, err_count} !== 29'd0) begin
            n_fail++; $display("FAIL reset_status: got %h required 0", {update_valid, update_ch, err_valid, err_code, err_count});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (from_uart_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_early: got %b required 0", from_uart_ready);
        end
        @(negedge clk);
        n_checks++;
        if (from_uart_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_rise: got %b required 1", from_uart_ready);
        end
        #1;
    endtask

    task automatic test_frame(input string name, input int err_at, input int maxgap);
        model_frame(err_at);
        send_frame(err_at, 13, maxgap);
        idle(4);
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            n_checks++;
            if ({wave_sel[c*8 +: 8], adder[c*32 +: 32], amplitude[c*32 +: 32]} !== {exp_wave[c], exp_adder[c], exp_ampl[c]}) begin
                n_fail++; $display("FAIL %s ch%0d: got %h required %h", name, c, {wave_sel[c*8 +: 8], adder[c*32 +: 32], amplitude[c*32 +: 32]}, {exp_wave[c], exp_adder[c], exp_ampl[c]});
            end
        end
        n_checks++;
        if ({err_code, err_count, update_ch} !== {exp_code, exp_count, exp_upd_ch}) begin
            n_fail++; $display("FAIL %s status: code/count/ch got %0d/%0d/%0d required %0d/%0d/%0d", name, err_code, err_count, update_ch, exp_code, exp_count, exp_upd_ch);
        end
        n_checks++;
        if (upd_seen != exp_upd || err_seen != exp_errp) begin
            n_fail++; $display("FAIL %s pulses: upd/err got %0d/%0d required %0d/%0d", name, upd_seen, err_seen, exp_upd, exp_errp);
        end
        #1;
    endtask

    task automatic test_good_frame();
        build_frame(8'h01, 8'h02, 32'h00010000, 32'h000000FF);
        test_frame("good_frame", -1, 0);
    endtask

    task automatic test_bad_checksum();
        build_frame(8'h01, 8'h02, 32'h00010000, 32'h000000FF);
        frm[11] = 8'hFC;
        test_frame("bad_checksum", -1, 0);
    endtask

    task automatic test_bad_channel();
        build_frame(8'h07, 8'h02, 32'h00010000, 32'h000000FF);
        test_frame("bad_channel", -1, 0);
    endtask

    task automatic test_timeout();
        build_frame(8'h02, 8'h05, $urandom, $urandom);
        send_frame(-1, 5, 0);
        idle(94);
        @(negedge clk);
        n_checks++;
        if (err_seen != exp_errp) begin
            n_fail++; $display("FAIL timeout_early: err pulses got %0d required %0d", err_seen, exp_errp);
        end
        #1;
        idle(10);
        model_err(3'd2);
        @(negedge clk);
        n_checks++;
        if (err_seen != exp_errp || err_code !== exp_code) begin
            n_fail++; $display("FAIL timeout: pulses/code got %0d/%0d required %0d/%0d", err_seen, err_code, exp_errp, exp_code);
        end
        #1;
        build_frame(8'h02, 8'h05, $urandom, $urandom);
        test_frame("after_timeout", -1, 2);
    endtask

    task automatic test_uart_error();
        build_frame(8'h00, 8'h03, $urandom, $urandom);
        test_frame("uart_error", 2, 0);
        send_byte(8'h00, 1'b0, 1);
        send_byte(8'h41, 1'b0, 1);
        build_frame(8'h00, 8'h04, $urandom, $urandom);
        test_frame("junk_then_good", -1, 1);
    endtask

    task automatic test_random();
        logic [7:0] j;
        int kind, err_at;
        for (int n = 0; n < 40; n++) begin
            build_frame(8'($urandom_range(NCH, 0)), 8'($urandom), $urandom, $urandom);
            kind = $urandom_range(3, 0);
            err_at = -1;
            if (kind == 1) frm[11] = frm[11] ^ 8'($urandom_range(255, 1));
            if (kind == 2) frm[12] = 8'h65 ^ 8'($urandom_range(255, 1));
            if (kind == 3) err_at = $urandom_range(12, 0);
            for (int k = $urandom_range(2, 0); k > 0; k--) begin
                j = 8'($urandom);
                if (j == 8'h73) j = 8'h00;
                send_byte(j, 1'b0, 0);
            end
            test_frame("random", err_at, 3);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            build_frame(8'(n), 8'($urandom), $urandom, $urandom);
            model_frame(-1);
            send_frame(-1, 13, 0);
        end
        build_frame(8'h03, 8'($urandom), $urandom, $urandom);
        test_frame("back_to_back", -1, 0);
    endtask

    task automatic test_reset_mid_frame();
        build_frame(8'h03, 8'h09, $urandom, $urandom);
        send_frame(-1, 9, 1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            n_checks++;
            if ({wave_sel[c*8 +: 8], adder[c*32 +: 32], amplitude[c*32 +: 32]} !== {exp_wave[c], exp_adder[c], exp_ampl[c]}) begin
                n_fail++; $display("FAIL mid_reset ch%0d: got %h required %h", c, {wave_sel[c*8 +: 8], adder[c*32 +: 32], amplitude[c*32 +: 32]}, {exp_wave[c], exp_adder[c], exp_ampl[c]});
            end
        end
        n_checks++;
        if ({err_code, err_count} !== 19'd0) begin
            n_fail++; $display("FAIL mid_reset status: got %h required 0", {err_code, err_count});
        end
        #1;
        build_frame(8'h03, 8'h0A, $urandom, $urandom);
        test_frame("after_reset", -1, 1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_channel();
        test_timeout();
        test_uart_error();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
